// File: rtl/hdr_cfg_writer_pkg.sv
// Shared types and geometry for the header config writer.
package hdr_cfg_writer_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 128;
  localparam int SLOTS     = 8;
  localparam int BEATS     = 4;
  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    WR_S   = 2'd1,
    DONE_S = 2'd2,
    DROP_S = 2'd3
  } state_t;

  // RAM word address: {bank, slot, beat} == bank*32 + slot*4 + beat
  function automatic logic [ADDR_W-1:0] mk_addr(input logic bank,
                                                input logic [2:0] slot,
                                                input logic [1:0] beat);
    return {bank, slot, beat};
  endfunction

endpackage

// File: rtl/hwm_err_counter.sv
// Saturating malformed-header counter.
module hwm_err_counter
  import hdr_cfg_writer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [ERR_CNT_W-1:0] cnt
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + ERR_CNT_W'(1);
  end

endmodule

// File: rtl/hdr_cfg_writer.sv
// Writes 4-beat headers into the inactive bank of PKT_HDR_RAM and tracks
// which slots hold a committed header.
module hdr_cfg_writer
  import hdr_cfg_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_hwm_addr_shift,
  input  logic              in_hwm_hdr_valid,
  input  logic              in_hwm_hdr_sop,
  input  logic              in_hwm_hdr_eop,
  input  logic [2:0]        in_hwm_hdr_slot,
  input  logic [DATA_W-1:0] in_hwm_hdr_data,
  output logic              out_hwm_hdr_ready,
  output logic              out_hwm_pkt_hdr_wr,
  output logic [ADDR_W-1:0] out_hwm_pkt_hdr_addr,
  output logic [DATA_W-1:0] out_hwm_pkt_hdr,
  output logic              out_hwm_slot_done,
  output logic [2:0]        out_hwm_slot_id,
  output logic [SLOTS-1:0]  out_hwm_slot_vld0,
  output logic [SLOTS-1:0]  out_hwm_slot_vld1,
  input  logic              in_hwm_vld_clr,
  output logic [15:0]       out_hwm_err_cnt
);

  state_t            state, state_nx;
  logic [1:0]        beat, beat_nx;
  logic              bank, bank_nx;
  logic [2:0]        slot, slot_nx;
  logic              acc, wr_nx, err_inc;
  logic [ADDR_W-1:0] addr_nx;
  logic [SLOTS-1:0]  set_mask;

  assign acc      = in_hwm_hdr_valid && out_hwm_hdr_ready;
  assign set_mask = (state == DONE_S) ? (SLOTS'(1) << slot) : '0;

  // Next-state, write strobe and error decode.
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    bank_nx  = bank;
    slot_nx  = slot;
    wr_nx    = 1'b0;
    addr_nx  = '0;
    err_inc  = 1'b0;
    case (state)
      IDLE_S: if (acc) begin
        if (in_hwm_hdr_sop) begin
          bank_nx  = ~in_hwm_addr_shift;
          slot_nx  = in_hwm_hdr_slot;
          wr_nx    = 1'b1;
          addr_nx  = mk_addr(~in_hwm_addr_shift, in_hwm_hdr_slot, 2'd0);
          beat_nx  = 2'd1;
          state_nx = WR_S;
        end else begin
          err_inc = 1'b1;
        end
      end
      WR_S: if (acc) begin
        if (in_hwm_hdr_sop) begin
          // abort current header, this beat restarts a new one
          err_inc  = 1'b1;
          bank_nx  = ~in_hwm_addr_shift;
          slot_nx  = in_hwm_hdr_slot;
          wr_nx    = 1'b1;
          addr_nx  = mk_addr(~in_hwm_addr_shift, in_hwm_hdr_slot, 2'd0);
          beat_nx  = 2'd1;
        end else begin
          wr_nx   = 1'b1;
          addr_nx = mk_addr(bank, slot, beat);
          if (beat == 2'd3) begin
            beat_nx = 2'd0;
            if (in_hwm_hdr_eop) state_nx = DONE_S;
            else begin
              err_inc  = 1'b1;
              state_nx = DROP_S;
            end
          end else if (in_hwm_hdr_eop) begin
            err_inc  = 1'b1;
            beat_nx  = 2'd0;
            state_nx = IDLE_S;
          end else begin
            beat_nx = beat + 2'd1;
          end
        end
      end
      DONE_S: state_nx = IDLE_S;
      DROP_S: if (acc && in_hwm_hdr_eop) state_nx = IDLE_S;
      default: state_nx = IDLE_S;
    endcase
  end

  // All registered state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE_S;
      beat                 <= 2'd0;
      bank                 <= 1'b0;
      slot                 <= 3'd0;
      out_hwm_hdr_ready    <= 1'b0;
      out_hwm_pkt_hdr_wr   <= 1'b0;
      out_hwm_pkt_hdr_addr <= '0;
      out_hwm_pkt_hdr      <= '0;
      out_hwm_slot_done    <= 1'b0;
      out_hwm_slot_id      <= 3'd0;
      out_hwm_slot_vld0    <= '0;
      out_hwm_slot_vld1    <= '0;
    end else begin
      state              <= state_nx;
      beat               <= beat_nx;
      bank               <= bank_nx;
      slot               <= slot_nx;
      out_hwm_hdr_ready  <= (state_nx != DONE_S);
      out_hwm_pkt_hdr_wr <= wr_nx;
      if (wr_nx) begin
        out_hwm_pkt_hdr_addr <= addr_nx;
        out_hwm_pkt_hdr      <= in_hwm_hdr_data;
      end
      out_hwm_slot_done <= (state_nx == DONE_S);
      if (state_nx == DONE_S) out_hwm_slot_id <= slot_nx;
      // a commit in the same cycle as a clear keeps its own bit
      out_hwm_slot_vld0 <= (in_hwm_vld_clr ? '0 : out_hwm_slot_vld0) | (bank ? '0 : set_mask);
      out_hwm_slot_vld1 <= (in_hwm_vld_clr ? '0 : out_hwm_slot_vld1) | (bank ? set_mask : '0);
    end
  end

  hwm_err_counter u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .cnt   (out_hwm_err_cnt)
  );

endmodule

// File: tb/tb_hdr_cfg_writer.sv
// Directed bench for hdr_cfg_writer.
module tb_hdr_cfg_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         addr_shift, hdr_valid, hdr_sop, hdr_eop, vld_clr;
  logic [2:0]   hdr_slot;
  logic [127:0] hdr_data;
  logic         ready, wr, slot_done;
  logic [5:0]   addr;
  logic [127:0] wdata;
  logic [2:0]   slot_id;
  logic [7:0]   vld0, vld1;
  logic [15:0]  err_cnt;

  int ncmp = 0;
  int nerr = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wr_base, done_base;

  always #5 clk = ~clk;

  hdr_cfg_writer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_hwm_addr_shift    (addr_shift),
    .in_hwm_hdr_valid     (hdr_valid),
    .in_hwm_hdr_sop       (hdr_sop),
    .in_hwm_hdr_eop       (hdr_eop),
    .in_hwm_hdr_slot      (hdr_slot),
    .in_hwm_hdr_data      (hdr_data),
    .out_hwm_hdr_ready    (ready),
    .out_hwm_pkt_hdr_wr   (wr),
    .out_hwm_pkt_hdr_addr (addr),
    .out_hwm_pkt_hdr      (wdata),
    .out_hwm_slot_done    (slot_done),
    .out_hwm_slot_id      (slot_id),
    .out_hwm_slot_vld0    (vld0),
    .out_hwm_slot_vld1    (vld1),
    .in_hwm_vld_clr       (vld_clr),
    .out_hwm_err_cnt      (err_cnt)
  );

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (wr)        wr_cnt++;
    if (slot_done) done_cnt++;
  end

  function automatic logic [127:0] mk(input logic [7:0] k);
    return {4{24'hC0DE00, k}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // drive one beat, then check the registered write one cycle later
  task automatic send(input logic sop, input logic eop, input logic [2:0] s,
                      input logic [7:0] k, input logic exp_wr, input logic [5:0] exp_addr);
    hdr_valid = 1'b1; hdr_sop = sop; hdr_eop = eop; hdr_slot = s; hdr_data = mk(k);
    @(posedge clk); #1;
    chk("wr", wr, exp_wr);
    if (exp_wr) begin
      chk("addr", addr, exp_addr);
      chk("data", wdata, mk(k));
    end
  endtask

  task automatic idle();
    hdr_valid = 1'b0; hdr_sop = 1'b0; hdr_eop = 1'b0;
    @(posedge clk); #1;
  endtask

  // clean 4-beat header; ends in the DONE cycle
  task automatic hdr4(input logic [2:0] s, input logic [5:0] base, input logic [7:0] k);
    send(1, 0, s, k,      1, base);
    send(0, 0, 0, k + 1,  1, base + 6'd1);
    send(0, 0, 0, k + 2,  1, base + 6'd2);
    send(0, 1, 0, k + 3,  1, base + 6'd3);
    chk("done_rdy", ready, 1'b0);
    chk("done", slot_done, 1'b1);
    chk("done_id", slot_id, s);
  endtask

  task automatic chk_reset_outs();
    chk("rst_wr", wr, 1'b0);
    chk("rst_addr", addr, 6'd0);
    chk("rst_data", wdata, 128'd0);
    chk("rst_done", slot_done, 1'b0);
    chk("rst_id", slot_id, 3'd0);
    chk("rst_vld0", vld0, 8'h00);
    chk("rst_vld1", vld1, 8'h00);
    chk("rst_err", err_cnt, 16'd0);
    chk("rst_rdy", ready, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; addr_shift = 1'b0; hdr_valid = 1'b0; hdr_sop = 1'b0;
    hdr_eop = 1'b0; vld_clr = 1'b0; hdr_slot = 3'd0; hdr_data = '0;
    #22;
    chk_reset_outs();
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rdy_pre_edge", ready, 1'b0);
    @(posedge clk); #1;
    chk("rdy_post_edge", ready, 1'b1);

    // bank 1 (shift=0), slot 2 -> 40..43
    hdr4(3'd2, 6'd40, 8'h10);
    idle();
    chk("s1_done_clr", slot_done, 1'b0);
    chk("s1_rdy", ready, 1'b1);
    chk("s1_vld1", vld1, 8'h04);
    chk("s1_vld0", vld0, 8'h00);
    chk("s1_err", err_cnt, 16'd0);

    // bank 0 (shift=1), slot 7 -> 28..31; shift toggles mid-header
    addr_shift = 1'b1;
    send(1, 0, 3'd7, 8'h20, 1, 6'd28);
    addr_shift = 1'b0;
    send(0, 0, 0, 8'h21, 1, 6'd29);
    addr_shift = 1'b1;
    send(0, 0, 0, 8'h22, 1, 6'd30);
    send(0, 1, 0, 8'h23, 1, 6'd31);
    chk("s2_done", slot_done, 1'b1);
    chk("s2_id", slot_id, 3'd7);
    idle();
    chk("s2_vld0", vld0, 8'h80);
    chk("s2_vld1", vld1, 8'h04);

    // clear, then short header (eop on 2nd beat)
    vld_clr = 1'b1; idle(); vld_clr = 1'b0;
    chk("clr_vld0", vld0, 8'h00);
    chk("clr_vld1", vld1, 8'h00);
    addr_shift = 1'b0;
    done_base = done_cnt;
    send(1, 0, 3'd5, 8'h30, 1, 6'd52);
    send(0, 1, 0, 8'h31, 1, 6'd53);
    idle();
    chk("s3_err", err_cnt, 16'd1);
    chk("s3_nodone", done_cnt - done_base, 0);
    chk("s3_vld1", vld1, 8'h00);
    hdr4(3'd5, 6'd52, 8'h38);
    idle();
    chk("s3_vld1_ok", vld1, 8'h20);

    // 4th beat without eop, then two dropped beats
    addr_shift = 1'b1;
    wr_base = wr_cnt; done_base = done_cnt;
    send(1, 0, 3'd3, 8'h40, 1, 6'd12);
    send(0, 0, 0, 8'h41, 1, 6'd13);
    send(0, 0, 0, 8'h42, 1, 6'd14);
    send(0, 0, 0, 8'h43, 1, 6'd15);
    chk("s4_err", err_cnt, 16'd2);
    send(0, 0, 0, 8'h44, 0, 6'd0);
    send(0, 1, 0, 8'h45, 0, 6'd0);
    idle();
    chk("s4_wrs", wr_cnt - wr_base, 4);
    chk("s4_nodone", done_cnt - done_base, 0);
    chk("s4_err2", err_cnt, 16'd2);
    chk("s4_vld0", vld0, 8'h00);

    // sop slot 1 interrupted by sop slot 3 on 3rd beat
    vld_clr = 1'b1; idle(); vld_clr = 1'b0;
    addr_shift = 1'b0;
    done_base = done_cnt;
    send(1, 0, 3'd1, 8'h50, 1, 6'd36);
    send(0, 0, 0, 8'h51, 1, 6'd37);
    hdr4(3'd3, 6'd44, 8'h58);
    chk("s5_err", err_cnt, 16'd3);
    idle();
    chk("s5_ndone", done_cnt - done_base, 1);
    chk("s5_vld1", vld1, 8'h08);
    chk("s5_vld0", vld0, 8'h00);

    // clear coincident with a commit: the new bit survives
    hdr4(3'd0, 6'd32, 8'h60);
    vld_clr = 1'b1; idle(); vld_clr = 1'b0;
    chk("s6_vld1", vld1, 8'h01);

    // reset mid-header, then resend
    addr_shift = 1'b1;
    send(1, 0, 3'd4, 8'h70, 1, 6'd16);
    send(0, 0, 0, 8'h71, 1, 6'd17);
    hdr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s7_rdy", ready, 1'b1);
    hdr4(3'd4, 6'd16, 8'h78);
    idle();
    chk("s7_vld0", vld0, 8'h10);
    chk("s7_vld1", vld1, 8'h00);
    chk("s7_err", err_cnt, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
